// File: rtl/rev_pkg.sv
// Shared definitions for the reverse_deser block: FSM state encoding, default
// word width and the bit-reversal helper.
package rev_pkg;

  localparam int REV_MAX_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } rev_state_e;

  // Mirrors the low `width` bits of din; bits at and above `width` return 0.
  function automatic logic [31:0] bit_reverse(input logic [31:0] din, input int width);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) begin
      if (k < width) r[width-1-k] = din[k];
    end
    return r;
  endfunction

endpackage

// File: rtl/rd_bit_counter.sv
// Bit-index counter for reverse_deser: synchronous clear, count enable and a
// terminal-count flag at MAX-1. Wraps to 0 when enabled at terminal count.
module rd_bit_counter
  import rev_pkg::*;
#(
  parameter int MAX = REV_MAX_DEFAULT,
  parameter int CW  = $clog2(MAX) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (i_en && o_tc)) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CW'(MAX - 1));

endmodule

// File: rtl/reverse_deser.sv
// Serial-in deserialiser that presents each collected word bit-reversed (first
// received bit at the MSB). Optional even parity output: REVERSE_DESER_PARITY_EN.
module reverse_deser
  import rev_pkg::*;
#(
  parameter int MAX = REV_MAX_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           sin,
  input  logic           sin_valid,
  input  logic           dout_ready,
  input  logic           ovr_clr,
  output logic [MAX-1:0] dout,
  output logic           dout_valid,
  output logic           busy,
  output logic           overrun
`ifdef REVERSE_DESER_PARITY_EN
  ,
  output logic           dout_par
`endif
);

  localparam int CW = $clog2(MAX) + 1;

  rev_state_e     r_state;
  logic [MAX-1:0] r_shreg;
  logic [MAX-1:0] r_dout;
  logic           r_dout_valid;
  logic           r_busy;
  logic           r_overrun;
  logic           r_dout_par;

  logic [CW-1:0]  w_cnt;
  logic           w_tc;
  logic           w_cnt_clr;
  logic           w_cnt_en;
  logic           w_ovr_evt;
  logic [MAX-1:0] w_next_shreg;
  logic [MAX-1:0] w_rev;

  assign w_cnt_clr = (r_state == ST_IDLE) && start;
  assign w_cnt_en  = (r_state == ST_SHIFT) && sin_valid;
  assign w_ovr_evt = (r_state == ST_HOLD) && sin_valid;

  rd_bit_counter #(.MAX(MAX), .CW(CW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  // Shift register as it will look once the current bit lands at index cnt.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned,
    // which would otherwise infer a latch.
    w_next_shreg = r_shreg;
    for (int k = 0; k < MAX; k++) begin
      if (w_cnt == CW'(k)) w_next_shreg[k] = sin;
    end
  end

  assign w_rev = MAX'(bit_reverse(32'(w_next_shreg), MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift register is plain flops, not a memory, so it is reset
      // along with the rest of the datapath.
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_dout_par   <= 1'b0;
    end else begin
      // A new overrun event wins over a simultaneous clear.
      if (w_ovr_evt) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SHIFT;
            r_shreg <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (sin_valid) begin
            r_shreg <= w_next_shreg;
            if (w_tc) begin
              r_state      <= ST_HOLD;
              r_dout       <= w_rev;
              r_dout_par   <= ^w_rev;
              r_dout_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (dout_ready) begin
            r_state      <= ST_IDLE;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

`ifdef REVERSE_DESER_PARITY_EN
  assign dout_par = r_dout_par;
`else
  logic w_unused_par;
  assign w_unused_par = r_dout_par;
`endif

endmodule

// File: doc/reverse_deser.md
REVERSE_DESER -- requirements
Module: reverse_deser

Interface
REQ-001 SHALL have parameter MAX, default 8, word width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, begins word collection when the block is idle.
REQ-005 SHALL have port sin, input, 1, serial data bit.
REQ-006 SHALL have port sin_valid, input, 1, qualifies sin on the current clk edge.
REQ-007 SHALL have port dout_ready, input, 1, downstream accepts dout.
REQ-008 SHALL have port ovr_clr, input, 1, synchronous clear of overrun.
REQ-009 SHALL have port dout, output, MAX, bit-reversed collected word.
REQ-010 SHALL have port dout_valid, output, 1, dout holds a complete word.
REQ-011 SHALL have port busy, output, 1, high in SHIFT and HOLD.
REQ-012 SHALL have port overrun, output, 1, sticky error flag.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and HOLD, encoded per the shared package.
REQ-014 IDLE->SHIFT SHALL occur on the clk edge with start=1; the bit counter and shift register SHALL clear on that edge.
REQ-015 In SHIFT, each edge with sin_valid=1 SHALL store sin at shreg[cnt] and increment cnt; sin SHALL be ignored when sin_valid=0.
REQ-016 The edge that accepts bit index MAX-1 SHALL move SHIFT->HOLD; dout_valid SHALL be high on the following cycle (latency 1 cycle from last bit).
REQ-017 In HOLD, dout SHALL equal the bit reversal of shreg, i.e. dout[MAX-1-k] = bit k, so the first received bit is dout MSB.
REQ-018 dout and dout_valid SHALL be registered and SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-019 HOLD->IDLE SHALL occur on the edge with dout_ready=1; dout_valid SHALL drop the next cycle; dout SHALL retain its last value.
REQ-020 start SHALL be ignored in SHIFT and HOLD; start with dout_ready in HOLD SHALL return to IDLE only, not restart.
REQ-021 sin_valid=1 in HOLD SHALL set overrun and discard the bit; overrun SHALL stay set until ovr_clr=1 or reset.
REQ-022 ovr_clr and a new overrun event on the same edge SHALL leave overrun set.
REQ-023 cnt SHALL be $clog2(MAX)+1 bits wide and SHALL never exceed MAX-1 while in SHIFT.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, cnt=0, shreg=0, dout=0, dout_valid=0, busy=0 and overrun=0, including mid-word.
REQ-025 After rst_n is released, the first edge SHALL behave as in IDLE.

Configuration
REQ-026 With macro REVERSE_DESER_PARITY_EN defined, the block SHALL add output dout_par, 1 bit, registered with dout, equal to the XOR of dout (even parity).
REQ-027 Without REVERSE_DESER_PARITY_EN, dout_par SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-028 Package rev_pkg SHALL hold the state enum typedef, the default MAX constant, and the automatic function bit_reverse (a loop over MAX bits).
REQ-029 The block SHALL contain one sub-module, rd_bit_counter: a counter with clear/enable and a terminal-count output at MAX-1.
REQ-030 The block SHALL contain no combinational path from any input to dout or dout_valid.

Verification
REQ-031 Reset: drive rst_n low mid-SHIFT after 3 bits -> all outputs 0 asynchronously; a new start then collects a full fresh word.
REQ-032 Basic: MAX=8; start, then bits 1,1,0,1,0,0,0,0 with sin_valid=1 -> dout=8'hD0 and dout_valid=1 one cycle after the 8th bit.
REQ-033 Gaps/backpressure: bits 1,0,0,0,0,0,0,0 with sin_valid gaps, dout_ready=0 for 5 cycles -> dout=8'h80 held stable, then drops valid after ready.
REQ-034 Overrun: sin_valid=1 in HOLD -> overrun=1, dout unchanged; ovr_clr pulse -> overrun=0; ovr_clr plus event on the same edge -> stays 1.
REQ-035 Ignored start: pulse start mid-SHIFT and in HOLD -> no cnt reset, no restart; busy stays high until dout_ready.
REQ-036 Parity build: with REVERSE_DESER_PARITY_EN, dout=8'hD0 -> dout_par=1; dout=8'h80 -> dout_par=1; dout=8'h00 -> dout_par=0.
